input_stream_sched: RTL
=======================

# input_stream_sched

Sequencer for the 2:1 operand-streaming mux at the input of the matrix-multiply core. After a start pulse it streams N tiles. Each tile is BEATS beats of operand A, then BEATS beats of operand B. For each beat it drives the mux select, the per-lane mux resets and the operand-buffer read address, and it honours downstream back-pressure. When the last tile ends it waits a fixed drain interval for the pipeline to empty, then pulses done.

## Interface
Parameters:
- ADDR_W, 8: width of rd_addr; BEATS ≤ 2^ADDR_W
- BEATS, 16: beats per operand block, ≥ 2
- CNT_W, 8: width of num_tiles and the tile counter
- DRAIN_CYC, 4: drain cycles after the last beat, ≥ 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- num_tiles  in  CNT_W  tile count; latched on an accepted start
- src_ready  in  1  mux/core accepts a beat this cycle
- rd_en  out  1  a beat is issued this cycle
- rd_addr  out  ADDR_W  beat index within the current operand block
- mux_sel  out  1  0 = operand A, 1 = operand B
- mux_reset  out  2  bit0 = clear lane A, bit1 = clear lane B; active-high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
States and transitions:
- IDLE → ARM on start.
- ARM → LOAD_A after 1 cycle. If the latched num_tiles = 0, ARM → DONE instead.
- LOAD_A → LOAD_B on the issued beat with rd_addr = BEATS-1.
- LOAD_B → LOAD_A on the issued last beat, unless it completes the last tile; then LOAD_B → DRAIN.
- DRAIN → DONE after DRAIN_CYC cycles.
- DONE → IDLE after 1 cycle.

Outputs (Moore decode of the state register, except rd_en):
- mux_reset = 2'b11 in IDLE, ARM, DRAIN and DONE; 2'b10 in LOAD_A (lane B held clear); 2'b01 in LOAD_B.
- mux_sel = 1 in LOAD_B only.
- busy = 1 in every state except IDLE.
- done = 1 in DONE only.
- rd_en = (LOAD_A or LOAD_B) and src_ready. This is the only combinational output.

Counters and back-pressure:
- rd_addr increments on each rd_en and wraps to 0 on the last beat of a block.
- When src_ready = 0, rd_addr, the tile counter and the state all hold.
- The tile counter increments on the last beat of LOAD_B. The tile is last when the counter equals num_tiles-1, compared at CNT_W bits.
- num_tiles is sampled only on an accepted start. Later changes have no effect.

Boundary conditions:
- start while busy: ignored, with no effect on counters.
- start in the same cycle as done: ignored, because the block is still in DONE. It is accepted on the next cycle, in IDLE.
- num_tiles = 2^CNT_W-1: all tiles are streamed; the counter does not overflow.
- rst asserted mid-operation: immediately returns to IDLE with all counters 0. No done pulse.

Reset values: rd_en 0, rd_addr 0, mux_sel 0, mux_reset 2'b11, busy 0, done 0.

## Timing
- start sampled at edge t: ARM during cycle t+1; LOAD_A from t+2.
- First rd_en is at t+2 if src_ready = 1.
- With src_ready held high, done is high in cycle t+2+2·BEATS·N+DRAIN_CYC.
- N = 0: done is high in cycle t+2.
- Each src_ready low cycle during a LOAD state delays all later events by exactly one cycle.
- A/B switch: the mux_sel and mux_reset change coincides with the first beat of the new block. There is no bubble between blocks or between tiles.

## Structure
- Shared package holds:
  - state enum: IDLE, ARM, LOAD_A, LOAD_B, DRAIN, DONE
  - mux_reset encodings: CLR_BOTH = 2'b11, RUN_A = 2'b10, RUN_B = 2'b01
- One sub-module, beat_counter: a parameterized modulo counter with enable and a terminal-count flag, instantiated for rd_addr (modulo BEATS) and for the drain count.
- The tile counter stays inline in the top level.

## Test plan
- Basic run, BEATS = 4, N = 2, src_ready = 1:
  - rd_addr sequence is 0,1,2,3 repeated 4 times.
  - mux_sel runs A,B,A,B blocks.
  - mux_reset runs 11,10,01,10,01,11.
  - done at t+2+16+4 = t+22.
- N = 0: ARM then DONE, with no rd_en and done at t+2.
- Back-pressure: src_ready low for 3 cycles at rd_addr = 2 of the LOAD_B block → rd_addr and mux_sel hold, rd_en = 0, done is late by exactly 3 cycles.
- start pulsed while busy, and again in the DONE cycle → both ignored and num_tiles not relatched. A start one cycle later starts a new run.
- rst asserted at rd_addr = 1 of LOAD_B → immediately busy = 0, mux_reset = 11, rd_addr = 0, no done. A later start runs cleanly.
- Parameter corner, BEATS = 2, DRAIN_CYC = 1, N = 255 (CNT_W = 8) → 1020 beats and done at t+2+1020+1 = t+1023.

Source files
------------

// File: rtl/input_stream_sched_pkg.sv
// Shared types and encodings for the operand-streaming sequencer.
package input_stream_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      LOAD_A,
      LOAD_B,
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] CLR_BOTH = 2'b11;
   localparam logic [1:0] RUN_A    = 2'b10;
   localparam logic [1:0] RUN_B    = 2'b01;

   // Counter width able to hold 0..modulo-1, never narrower than one bit.
   function automatic int cnt_width(input int modulo);
      return (modulo > 1) ? $clog2(modulo) : 1;
   endfunction

endpackage

// File: rtl/input_stream_sched_beat_counter.sv
// Modulo-MODULO up-counter with enable; o_tc flags the last count before wrap.
module beat_counter #(
   parameter int MODULO = 16,
   parameter int W      = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   assign o_tc  = (r_cnt == W'(MODULO - 1));
   assign o_cnt = r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tc ? '0 : r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/input_stream_sched.sv
// Sequencer for the A/B operand-streaming mux: streams N tiles of A then B
// blocks under back-pressure, drains the pipeline and pulses done.
//
// state  | meaning
// IDLE   | waiting for start, both lanes cleared
// ARM    | num_tiles latched, one setup cycle
// LOAD_A | issuing operand-A beats, lane B held clear
// LOAD_B | issuing operand-B beats, lane A held clear
// DRAIN  | fixed wait for the core pipeline to empty
// DONE   | one-cycle completion pulse
module input_stream_sched
   import input_stream_sched_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BEATS     = 16,
   parameter int CNT_W     = 8,
   parameter int DRAIN_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [CNT_W-1:0]  i_num_tiles,
   input  logic              i_src_ready,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_mux_sel,
   output logic [1:0]        o_mux_reset,
   output logic              o_busy,
   output logic              o_done
);

   localparam int DRAIN_W = cnt_width(DRAIN_CYC);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_num_tiles;
   logic [CNT_W-1:0]   r_tile_cnt;
   logic               w_loading;
   logic               w_rd_en;
   logic               w_addr_tc;
   logic               w_block_end;
   logic               w_last_tile;
   logic               w_drain_tc;
   logic [DRAIN_W-1:0] w_drain_cnt_unused;

   assign w_loading   = (r_state == LOAD_A) || (r_state == LOAD_B);
   assign w_rd_en     = w_loading && i_src_ready;
   assign w_block_end = w_rd_en && w_addr_tc;
   assign w_last_tile = (r_tile_cnt == r_num_tiles - CNT_W'(1));
   assign o_rd_en     = w_rd_en;

   // Wraps on the last beat of every block, so it is back at 0 between blocks.
   beat_counter #(
      .MODULO (BEATS),
      .W      (ADDR_W)
   ) u_addr_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_rd_en),
      .o_cnt (o_rd_addr),
      .o_tc  (w_addr_tc)
   );

   // Enabled on every DRAIN cycle, so it wraps back to 0 as DRAIN ends.
   beat_counter #(
      .MODULO (DRAIN_CYC),
      .W      (DRAIN_W)
   ) u_drain_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (r_state == DRAIN),
      .o_cnt (w_drain_cnt_unused),
      .o_tc  (w_drain_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_num_tiles <= '0;
         r_tile_cnt  <= '0;
      end else if (r_state == IDLE && i_start) begin
         r_num_tiles <= i_num_tiles;
         r_tile_cnt  <= '0;
      end else if (r_state == LOAD_B && w_block_end) begin
         r_tile_cnt <= w_last_tile ? '0 : r_tile_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      o_mux_reset = CLR_BOTH;
      o_mux_sel   = 1'b0;
      o_busy      = 1'b1;
      o_done      = 1'b0;
      case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start) w_next = ARM;
         end
         ARM: begin
            w_next = (r_num_tiles == '0) ? DONE : LOAD_A;
         end
         LOAD_A: begin
            o_mux_reset = RUN_A;
            if (w_block_end) w_next = LOAD_B;
         end
         LOAD_B: begin
            o_mux_reset = RUN_B;
            o_mux_sel   = 1'b1;
            if (w_block_end) w_next = w_last_tile ? DRAIN : LOAD_A;
         end
         DRAIN: begin
            if (w_drain_tc) w_next = DONE;
         end
         DONE: begin
            o_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule
